// File: rtl/elevator_interface_pkg.sv
// Shared encodings for the four-floor elevator demo: FSM states, floor limits and
// seven-segment digit patterns (active-low {dp,g,f,e,d,c,b,a}).
package elevator_interface_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StUp   = 2'd1,
    StDown = 2'd2,
    StDoor = 2'd3
  } state_e;

  localparam logic [1:0] MIN_FLOOR = 2'd0;
  localparam logic [1:0] MAX_FLOOR = 2'd3;

  localparam logic [7:0] SEG_DIGIT_1 = 8'hF9;
  localparam logic [7:0] SEG_DIGIT_2 = 8'hA4;
  localparam logic [7:0] SEG_DIGIT_3 = 8'hB0;
  localparam logic [7:0] SEG_DIGIT_4 = 8'h99;

  function automatic logic [3:0] sat_nibble(input logic [15:0] v);
    return (v > 16'd15) ? 4'hF : v[3:0];
  endfunction

endpackage

// File: rtl/seg7_floor.sv
// Floor number (Level+1) to active-low seven-segment pattern; decimal point lit while moving.
module seg7_floor
  import elevator_interface_pkg::*;
(
  input  logic [1:0] level,
  input  logic       moving,
  output logic [7:0] seg
);

  always_comb begin
    seg = SEG_DIGIT_1;
    unique case (level)
      2'd0: seg = SEG_DIGIT_1;
      2'd1: seg = SEG_DIGIT_2;
      2'd2: seg = SEG_DIGIT_3;
      2'd3: seg = SEG_DIGIT_4;
    endcase
    if (moving) seg[7] = 1'b0;
  end

endmodule

// File: rtl/elevator_interface.sv
// Four-floor elevator controller: request capture, one-floor-at-a-time travel FSM with
// door timer, emergency hold, and registered display/debug outputs.
module elevator_interface
  import elevator_interface_pkg::*;
#(
  parameter int unsigned FLOOR_TICKS = 16,
  parameter int unsigned DOOR_TICKS  = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       switch1,
  input  logic       switch2,
  input  logic       switch3,
  input  logic       Button1,
  input  logic       Button2,
  input  logic       Button3,
  input  logic       Button4,
  input  logic       Button5,
  input  logic       Button6,
  input  logic       Button7,
  output logic       exit,
  output logic [1:0] Level,
  output logic [7:0] sevenseg,
  output logic [1:0] test_out,
  output logic [3:0] reloj
);

  localparam logic [15:0] FloorLoad = 16'(FLOOR_TICKS - 1);
  localparam logic [15:0] DoorLoad  = 16'(DOOR_TICKS - 1);

  state_e      state_q, state_d;
  logic [15:0] timer_q, timer_d;
  logic [1:0]  level_q, level_d;
  logic [1:0]  target_q, target_d;
  logic        pending_q, pending_d;
  logic        b1_q, b1_qq, b4_q, b4_qq, b5_q, b5_qq, b6_q, hold_q;

  logic        rise1, rise4, rise5;
  logic        req_sw, req_up, req_dn, req_any, door_req, accept, moving;
  logic [1:0]  req_floor, step, next_up, next_dn;
  logic [2:0]  code;
  logic [7:0]  seg_next;
  logic        unused_buttons;

  assign unused_buttons = Button2 ^ Button3;

  always_ff @(posedge clk) begin
    if (reset) begin
      {b1_q, b1_qq, b4_q, b4_qq, b5_q, b5_qq, b6_q, hold_q} <= '0;
    end else begin
      b1_q   <= Button1;
      b1_qq  <= b1_q;
      b4_q   <= Button4;
      b4_qq  <= b4_q;
      b5_q   <= Button5;
      b5_qq  <= b5_q;
      b6_q   <= Button6;
      hold_q <= Button7;
    end
  end

  assign rise1    = b1_q & ~b1_qq;
  assign rise4    = b4_q & ~b4_qq;
  assign rise5    = b5_q & ~b5_qq;
  assign code     = {switch3, switch2, switch1};
  assign req_sw   = ~enable & rise5;
  assign req_up   = enable & b6_q & rise4;
  assign req_dn   = enable & b6_q & rise1;
  // Submit takes precedence over the door-open key when both arrive together.
  assign door_req = ~enable & rise4 & ~rise5;
  assign req_any  = (req_sw | req_up | req_dn) && (state_q != StDoor);
  assign next_up  = (level_q == MAX_FLOOR) ? MAX_FLOOR : level_q + 2'd1;
  assign next_dn  = (level_q == MIN_FLOOR) ? MIN_FLOOR : level_q - 2'd1;
  assign step     = (state_q == StUp) ? next_up : next_dn;
  assign moving   = (state_q == StUp) || (state_q == StDown);

  always_comb begin
    req_floor = level_q;
    if (req_sw)      req_floor = (code > 3'd3) ? MAX_FLOOR : code[1:0];
    else if (req_up) req_floor = next_up;
    else if (req_dn) req_floor = next_dn;
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    level_d = level_q;
    accept  = 1'b0;
    if (!hold_q) begin
      case (state_q)
        StIdle: begin
          if (pending_q) begin
            accept = 1'b1;
            if (target_q > level_q) begin
              state_d = StUp;
              timer_d = FloorLoad;
            end else if (target_q < level_q) begin
              state_d = StDown;
              timer_d = FloorLoad;
            end else begin
              state_d = StDoor;
              timer_d = DoorLoad;
            end
          end else if (door_req) begin
            state_d = StDoor;
            timer_d = DoorLoad;
          end
        end
        StUp, StDown: begin
          if (timer_q == '0) begin
            level_d = step;
            // Keep going only if the (possibly updated) target lies further ahead.
            if ((state_q == StUp && target_q > step) || (state_q == StDown && target_q < step)) begin
              timer_d = FloorLoad;
            end else begin
              state_d = StDoor;
              timer_d = DoorLoad;
            end
          end else begin
            timer_d = timer_q - 16'd1;
          end
        end
        StDoor: begin
          if (timer_q == '0) begin
            state_d = StIdle;
          end else begin
            timer_d = timer_q - 16'd1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    pending_d = pending_q;
    target_d  = target_q;
    if (req_any) begin
      pending_d = 1'b1;
      target_d  = req_floor;
    end else if (accept) begin
      pending_d = 1'b0;
    end
  end

  seg7_floor u_seg7_floor (
    .level  (level_q),
    .moving (moving),
    .seg    (seg_next)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      timer_q   <= '0;
      level_q   <= MIN_FLOOR;
      target_q  <= MIN_FLOOR;
      pending_q <= 1'b0;
      exit      <= 1'b0;
      Level     <= MIN_FLOOR;
      sevenseg  <= SEG_DIGIT_1;
      test_out  <= 2'd0;
      reloj     <= 4'd0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      level_q   <= level_d;
      target_q  <= target_d;
      pending_q <= pending_d;
      exit      <= (state_q == StDoor);
      Level     <= level_q;
      sevenseg  <= seg_next;
      test_out  <= state_q;
      reloj     <= sat_nibble(timer_q);
    end
  end

endmodule

// File: tb/tb_elevator_interface.sv
// Scoreboard bench: each request pushes the expected arrival (floor, cycle); a monitor
// pops on every door opening and checks floor, display, timing and door duration.
module tb_elevator_interface;

  typedef struct {
    int floor;
    int start;
    int due;
  } exp_t;

  localparam logic [7:0] SEG_NODP [4] = '{8'hF9, 8'hA4, 8'hB0, 8'h99};
  localparam logic [7:0] SEG_DP   [4] = '{8'h79, 8'h24, 8'h30, 8'h19};

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b0;
  logic switch1 = 1'b0, switch2 = 1'b0, switch3 = 1'b0;
  logic Button1 = 1'b0, Button2 = 1'b0, Button3 = 1'b0, Button4 = 1'b0;
  logic Button5 = 1'b0, Button6 = 1'b0, Button7 = 1'b0;
  logic       exit;
  logic [1:0] Level;
  logic [7:0] sevenseg;
  logic [1:0] test_out;
  logic [3:0] reloj;

  int   cyc = 0;
  int   vecs = 0;
  int   errs = 0;
  int   model_floor = 0;
  exp_t q[$];
  exp_t mon_e;
  logic prev_exit = 1'b0;
  logic prev_moving = 1'b0;
  int   door_cnt = 0;

  elevator_interface #(.FLOOR_TICKS(16), .DOOR_TICKS(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .switch1  (switch1),
    .switch2  (switch2),
    .switch3  (switch3),
    .Button1  (Button1),
    .Button2  (Button2),
    .Button3  (Button3),
    .Button4  (Button4),
    .Button5  (Button5),
    .Button6  (Button6),
    .Button7  (Button7),
    .exit     (exit),
    .Level    (Level),
    .sevenseg (sevenseg),
    .test_out (test_out),
    .reloj    (reloj)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    vecs++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  // Drive one button high for two cycles; t is the cycle count just before the press edge.
  task automatic press(input int which, output int t);
    @(negedge clk);
    t = cyc;
    case (which)
      1: Button1 = 1'b1;
      4: Button4 = 1'b1;
      5: Button5 = 1'b1;
      default: ;
    endcase
    repeat (2) @(negedge clk);
    Button1 = 1'b0;
    Button4 = 1'b0;
    Button5 = 1'b0;
  endtask

  // Arrival: 3 cycles of capture/accept, 16 per floor, one more for the registered output.
  task automatic expect_trip(input int tgt, input int t, input int extra);
    exp_t e;
    int k;
    k = (tgt > model_floor) ? tgt - model_floor : model_floor - tgt;
    e.floor = tgt;
    e.start = model_floor;
    e.due   = t + 4 + 16 * k + extra;
    q.push_back(e);
    model_floor = tgt;
  endtask

  task automatic sw_request(input int code, input int extra);
    int t;
    enable  = 1'b0;
    switch1 = code[0];
    switch2 = code[1];
    switch3 = code[2];
    press(5, t);
    expect_trip((code > 3) ? 3 : code, t, extra);
  endtask

  task automatic btn_request(input bit up);
    int t;
    int tgt;
    enable  = 1'b1;
    @(negedge clk);
    Button6 = 1'b1;
    press(up ? 4 : 1, t);
    Button6 = 1'b0;
    if (up) tgt = (model_floor == 3) ? 3 : model_floor + 1;
    else    tgt = (model_floor == 0) ? 0 : model_floor - 1;
    expect_trip(tgt, t, 0);
  endtask

  task automatic door_request();
    int t;
    exp_t e;
    enable = 1'b0;
    press(4, t);
    e.floor = model_floor;
    e.start = model_floor;
    e.due   = t + 3;
    q.push_back(e);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while ((q.size() != 0 || exit) && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("trip_completes", int'(n < 400), 1);
    repeat (2) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (exit && !prev_exit) begin
        if (q.size() == 0) begin
          chk("unexpected_door", 1, 0);
        end else begin
          mon_e = q.pop_front();
          chk("arrive_level", int'(Level), mon_e.floor);
          chk("arrive_seg", int'(sevenseg), int'(SEG_NODP[mon_e.floor]));
          chk("arrive_cycle", cyc, mon_e.due);
          chk("arrive_state", int'(test_out), 3);
        end
        door_cnt = 1;
      end else if (exit) begin
        door_cnt++;
      end
      if (!exit && prev_exit) chk("door_open_cycles", door_cnt, 8);
      if ((test_out == 2'd1 || test_out == 2'd2) && !prev_moving) begin
        if (q.size() == 0) begin
          chk("unexpected_move", 1, 0);
        end else begin
          chk("move_dir", int'(test_out), (q[0].floor > q[0].start) ? 1 : 2);
          chk("move_seg", int'(sevenseg), int'(SEG_DP[q[0].start]));
        end
      end
    end
    prev_exit   = exit;
    prev_moving = (test_out == 2'd1 || test_out == 2'd2);
  end

  initial begin
    repeat (30000) @(posedge clk);
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t;
    int lv0, r0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("reset_level", int'(Level), 0);
    chk("reset_exit", int'(exit), 0);
    chk("reset_state", int'(test_out), 0);
    chk("reset_reloj", int'(reloj), 0);
    chk("reset_seg", int'(sevenseg), 8'hF9);

    sw_request(7, 0); wait_done();
    sw_request(2, 0); wait_done();
    sw_request(1, 0); wait_done();
    door_request();   wait_done();
    sw_request(3, 0); wait_done();
    btn_request(1'b1); wait_done();
    btn_request(1'b0); wait_done();

    // Button-mode keys without shift must be ignored.
    enable  = 1'b1;
    Button6 = 1'b0;
    press(4, t);
    press(1, t);
    repeat (40) @(negedge clk);
    chk("noshift_state", int'(test_out), 0);
    chk("noshift_level", int'(Level), model_floor);

    // Emergency hold mid-trip freezes Level and reloj and delays arrival by the hold time.
    sw_request(0, 20);
    repeat (8) @(negedge clk);
    Button7 = 1'b1;
    repeat (3) @(negedge clk);
    lv0 = int'(Level);
    r0  = int'(reloj);
    repeat (17) @(negedge clk);
    chk("hold_level", int'(Level), lv0);
    chk("hold_reloj", int'(reloj), r0);
    chk("hold_moving", int'(test_out), 2);
    Button7 = 1'b0;
    wait_done();

    // Reset during an upward trip.
    sw_request(3, 0);
    repeat (20) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midreset_level", int'(Level), 0);
    chk("midreset_state", int'(test_out), 0);
    chk("midreset_exit", int'(exit), 0);
    reset = 1'b0;
    q.delete();
    model_floor = 0;
    repeat (60) @(negedge clk);
    chk("midreset_stays_idle", int'(test_out), 0);

    for (int i = 0; i < 14; i++) begin
      case ($urandom_range(0, 2))
        0: sw_request(int'($urandom_range(0, 7)), 0);
        1: btn_request(1'($urandom_range(0, 1)));
        default: door_request();
      endcase
      wait_done();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
